// File: rtl/sal_bk_pkg.sv
// Shared types and widths for the per-bank DRAM controller (sal_bank_ctrl).
// Timer width follows the widest T_*_WIDTH macro; each one can be overridden at build time.
`ifndef T_RC_WIDTH
`define T_RC_WIDTH 6
`endif
`ifndef T_RCD_WIDTH
`define T_RCD_WIDTH 4
`endif
`ifndef T_RP_WIDTH
`define T_RP_WIDTH 4
`endif
`ifndef T_RAS_WIDTH
`define T_RAS_WIDTH 6
`endif
`ifndef T_RTP_WIDTH
`define T_RTP_WIDTH 4
`endif
`ifndef T_WTP_WIDTH
`define T_WTP_WIDTH 4
`endif
`ifndef T_RFC_WIDTH
`define T_RFC_WIDTH 8
`endif

package sal_bk_pkg;
   localparam int ID_W  = 4;
   localparam int RA_W  = 14;
   localparam int CA_W  = 10;
   localparam int LEN_W = 4;
   localparam int BA_W  = 3;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int TMR_W = max_i(max_i(max_i(`T_RC_WIDTH, `T_RCD_WIDTH), max_i(`T_RP_WIDTH, `T_RAS_WIDTH)),
                                max_i(max_i(`T_RTP_WIDTH, `T_WTP_WIDTH), `T_RFC_WIDTH));

   typedef enum logic [1:0] {CLOSED, ACTIVE, REFRESHING} bk_state_t;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [RA_W-1:0]  ra;
      logic [CA_W-1:0]  ca;
      logic             wr;
      logic [LEN_W-1:0] len;
   } pend_req_t;
endpackage

// File: rtl/sal_bank_ctrl_if.sv
// Interfaces of the bank controller: timing parameters, request source and scheduler grants.
interface sal_timing_if;
   import sal_bk_pkg::*;
   logic [TMR_W-1:0] t_rc_m1, t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1;
   logic [TMR_W-1:0] row_open_cnt;

   modport src (output t_rc_m1, t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1, row_open_cnt);
   modport mon (input  t_rc_m1, t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_rfc_m1, row_open_cnt);
endinterface

interface sal_req_if;
   import sal_bk_pkg::*;
   logic             valid, ready, wr;
   logic [ID_W-1:0]  id;
   logic [RA_W-1:0]  ra;
   logic [CA_W-1:0]  ca;
   logic [LEN_W-1:0] len;

   modport src (output valid, id, ra, ca, wr, len, input  ready);
   modport dst (input  valid, id, ra, ca, wr, len, output ready);
endinterface

interface sal_sched_if;
   import sal_bk_pkg::*;
   logic             act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
   logic [BA_W-1:0]  ba;
   logic [RA_W-1:0]  ra;
   logic [CA_W-1:0]  ca;
   logic [ID_W-1:0]  id;
   logic [LEN_W-1:0] len;

   modport bk_ctrl (output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt, ba, ra, ca, id, len);
   modport sched   (input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt, ba, ra, ca, id, len);
endinterface

// File: rtl/sal_bk_timer.sv
// Saturating down-counter: load_val is taken on load, then counts down to zero and holds there.
module sal_bk_timer
   import sal_bk_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             is_zero
);
   logic [TMR_W-1:0] cnt_q;

   // NOTE: registers are written with <= so every flop samples pre-edge values, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              cnt_q <= '0;
      else if (load)           cnt_q <= load_val;
      else if (cnt_q != '0)    cnt_q <= cnt_q - TMR_W'(1);
   end

   assign is_zero = (cnt_q == '0);
endmodule

// File: rtl/sal_bank_ctrl.sv
// Per-bank open-page DRAM controller: one-entry request buffer, intra-bank timers, ACT/RD/WR/PRE grants.
// Optional refresh support (ref_req port, REF grant, REFRESHING state) is enabled by SAL_BK_REF_EN.
module sal_bank_ctrl
   import sal_bk_pkg::*;
#(
   parameter int BK_ID = 0
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef SAL_BK_REF_EN
   input  logic         ref_req,
`endif
   sal_timing_if.mon    timing_if,
   sal_req_if.dst       req_if,
   sal_sched_if.bk_ctrl sched_if
);
   bk_state_t        state_q, state_d;
   pend_req_t        pend_q;
   logic             pend_vld_q, pend_vld_d, ready_q, run_q;
   logic [RA_W-1:0]  open_row_q;
   logic [TMR_W-1:0] idle_q;
   logic             act, rd, wr, pre, rf, accept, ref_act;
   logic             rcd_z, ras_z, rc_z, rp_z, rtp_z, wtp_z, idle_z, close_ok, row_hit;

   sal_bk_timer u_rcd (.clk(clk), .rst_n(rst_n), .load(act), .load_val(timing_if.t_rcd_m1), .is_zero(rcd_z));
   sal_bk_timer u_ras (.clk(clk), .rst_n(rst_n), .load(act), .load_val(timing_if.t_ras_m1), .is_zero(ras_z));
   sal_bk_timer u_rc  (.clk(clk), .rst_n(rst_n), .load(act), .load_val(timing_if.t_rc_m1),  .is_zero(rc_z));
   sal_bk_timer u_rp  (.clk(clk), .rst_n(rst_n), .load(pre), .load_val(timing_if.t_rp_m1),  .is_zero(rp_z));
   sal_bk_timer u_rtp (.clk(clk), .rst_n(rst_n), .load(rd),  .load_val(timing_if.t_rtp_m1), .is_zero(rtp_z));
   sal_bk_timer u_wtp (.clk(clk), .rst_n(rst_n), .load(wr),  .load_val(timing_if.t_wtp_m1), .is_zero(wtp_z));

`ifdef SAL_BK_REF_EN
   logic rfc_z;
   assign ref_act = ref_req;
   sal_bk_timer u_rfc (.clk(clk), .rst_n(rst_n), .load(rf), .load_val(timing_if.t_rfc_m1), .is_zero(rfc_z));
`else
   assign ref_act = 1'b0;
`endif

   assign accept   = req_if.valid & ready_q;
   assign close_ok = ras_z & rtp_z & wtp_z;
   assign row_hit  = (pend_q.ra == open_row_q);
   assign idle_z   = (idle_q == '0);

   // run_q keeps every grant low while reset is asserted, whatever ref_req is doing.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
      state_d = state_q;
      act = 1'b0; rd = 1'b0; wr = 1'b0; pre = 1'b0; rf = 1'b0;
      if (run_q) begin
         case (state_q)
            CLOSED: begin
               if (ref_act && rp_z && rc_z) begin
                  rf = 1'b1; state_d = REFRESHING;
               end else if (pend_vld_q && rp_z && rc_z) begin
                  act = 1'b1; state_d = ACTIVE;
               end
            end
            ACTIVE: begin
               if (ref_act) begin
                  if (close_ok) begin pre = 1'b1; state_d = CLOSED; end
               end else if (pend_vld_q && row_hit) begin
                  if (rcd_z) begin rd = ~pend_q.wr; wr = pend_q.wr; end
               end else if (pend_vld_q || idle_z) begin
                  if (close_ok) begin pre = 1'b1; state_d = CLOSED; end
               end
            end
`ifdef SAL_BK_REF_EN
            REFRESHING: if (rfc_z) state_d = CLOSED;
`endif
            default: state_d = CLOSED;
         endcase
      end
   end

   assign pend_vld_d = (pend_vld_q & ~(rd | wr)) | accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLOSED;
         pend_vld_q <= 1'b0;
         ready_q    <= 1'b0;
         run_q      <= 1'b0;
         open_row_q <= '0;
         idle_q     <= '0;
      end else begin
         state_q    <= state_d;
         pend_vld_q <= pend_vld_d;
         ready_q    <= ~pend_vld_d;
         run_q      <= 1'b1;
         if (act) open_row_q <= pend_q.ra;
         if (act | rd | wr)
            idle_q <= timing_if.row_open_cnt;
         else if (state_q == ACTIVE && !pend_vld_q && !idle_z)
            idle_q <= idle_q - TMR_W'(1);
      end
   end

   // NOTE: the payload register has no reset; pend_vld_q qualifies it and the bus outputs are gated.
   always_ff @(posedge clk) begin
      if (accept) pend_q <= '{id: req_if.id, ra: req_if.ra, ca: req_if.ca, wr: req_if.wr, len: req_if.len};
   end

   assign req_if.ready     = ready_q;
   assign sched_if.act_gnt = act;
   assign sched_if.rd_gnt  = rd;
   assign sched_if.wr_gnt  = wr;
   assign sched_if.pre_gnt = pre;
   assign sched_if.ref_gnt = rf;
   assign sched_if.ba      = BA_W'(BK_ID);
   assign sched_if.ra      = (act | rd | wr) ? pend_q.ra  : '0;
   assign sched_if.ca      = (rd | wr)       ? pend_q.ca  : '0;
   assign sched_if.id      = (rd | wr)       ? pend_q.id  : '0;
   assign sched_if.len     = (rd | wr)       ? pend_q.len : '0;
endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Self-checking bench for sal_bank_ctrl: table of single-request cases plus hit/miss/reset/refresh sequences.
// Expected grants are queued with their absolute cycle and popped by a negedge monitor.
module tb_sal_bank_ctrl;
   import sal_bk_pkg::*;

   localparam int BK_ID = 2;

   typedef enum logic [2:0] {C_ACT, C_RD, C_WR, C_PRE, C_REF} cmd_e;

   typedef struct {
      int   cyc;
      cmd_e cmd;
      int   ra, ca, id, len;
   } exp_t;

   typedef struct {
      logic wr;
      int   ra, ca, id, len, roc;
      int   act_c, col_c, pre_c;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
`ifdef SAL_BK_REF_EN
   logic ref_req = 1'b0;
`endif
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];
   logic [4:0] gnts;

   sal_timing_if tif();
   sal_req_if    rif();
   sal_sched_if  sif();

   sal_bank_ctrl #(.BK_ID(BK_ID)) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef SAL_BK_REF_EN
      .ref_req(ref_req),
`endif
      .timing_if(tif),
      .req_if(rif),
      .sched_if(sif)
   );

   assign gnts = {sif.ref_gnt, sif.pre_gnt, sif.wr_gnt, sif.rd_gnt, sif.act_gnt};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic void push(input int c, input cmd_e cmd, input int ra, input int ca, input int id, input int len);
      exp_t e;
      e.cyc = c; e.cmd = cmd; e.ra = ra; e.ca = ca; e.id = id; e.len = len;
      sbq.push_back(e);
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && gnts != 5'b0) begin
         check("gnt_onehot", $countones(gnts), 1);
         check("gnt_ba", sif.ba, BK_ID);
         if (sbq.size() == 0) begin
            check("unexpected_gnt", gnts, 0);
         end else begin
            e = sbq.pop_front();
            check("gnt_cycle", cyc, e.cyc);
            check("gnt_cmd", gnts, 32'(5'b1 << e.cmd));
            if (e.cmd == C_ACT) check("act_ra", sif.ra, e.ra);
            if (e.cmd == C_RD || e.cmd == C_WR) begin
               check("col_ca", sif.ca, e.ca);
               check("col_id", sif.id, e.id);
               check("col_len", sif.len, e.len);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk); #1;
      rst_n = 1'b0; #1;
      check("rst_ready_async", rif.ready, 0);
      check("rst_gnts", gnts, 0);
      check("rst_ra", sif.ra, 0);
      sbq.delete();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      check("ready_first_cycle", rif.ready, 0);
      @(negedge clk);
      check("ready_after_reset", rif.ready, 1);
   endtask

   task automatic send(input logic wr, input int ra, input int ca, input int id, input int len, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      while (rif.ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("req_ready", rif.ready, 1);
      rif.valid = 1'b1; rif.wr = wr;
      rif.ra = RA_W'(ra); rif.ca = CA_W'(ca); rif.id = ID_W'(id); rif.len = LEN_W'(len);
      acc = cyc;
      @(posedge clk); #1;
      rif.valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vt[5];
      int   b, a2;

      rif.valid = 1'b0; rif.wr = 1'b0; rif.ra = '0; rif.ca = '0; rif.id = '0; rif.len = '0;
      tif.t_rcd_m1 = 2; tif.t_rp_m1 = 2; tif.t_ras_m1 = 7; tif.t_rc_m1 = 10;
      tif.t_rtp_m1 = 1; tif.t_wtp_m1 = 5; tif.t_rfc_m1 = 9; tif.row_open_cnt = 4;

      // Single requests: PRE lands at the latest of ras (c9), rtp/wtp expiry and idle expiry.
      vt[0] = '{wr: 1'b0, ra: 5,  ca: 'h21, id: 3,  len: 4, roc: 4, act_c: 1, col_c: 4, pre_c: 9};
      vt[1] = '{wr: 1'b1, ra: 5,  ca: 'h33, id: 7,  len: 1, roc: 4, act_c: 1, col_c: 4, pre_c: 10};
      vt[2] = '{wr: 1'b0, ra: 12, ca: 'h05, id: 9,  len: 8, roc: 0, act_c: 1, col_c: 4, pre_c: 9};
      vt[3] = '{wr: 1'b1, ra: 77, ca: 'h3F, id: 15, len: 2, roc: 0, act_c: 1, col_c: 4, pre_c: 10};
      vt[4] = '{wr: 1'b0, ra: 1,  ca: 'h10, id: 4,  len: 3, roc: 7, act_c: 1, col_c: 4, pre_c: 12};

      for (int i = 0; i < 5; i++) begin
         tif.row_open_cnt = TMR_W'(vt[i].roc);
         do_reset();
         send(vt[i].wr, vt[i].ra, vt[i].ca, vt[i].id, vt[i].len, b);
         push(b + vt[i].act_c, C_ACT, vt[i].ra, 0, 0, 0);
         push(b + vt[i].col_c, vt[i].wr ? C_WR : C_RD, vt[i].ra, vt[i].ca, vt[i].id, vt[i].len);
         push(b + vt[i].pre_c, C_PRE, 0, 0, 0, 0);
         idle(20);
         check("vec_sb_empty", sbq.size(), 0);
      end

      // Hit: write to the open row follows the read with no ACT; PRE waits for wtp (c12).
      tif.row_open_cnt = 4;
      do_reset();
      send(1'b0, 5, 7, 1, 2, b);
      push(b + 1, C_ACT, 5, 0, 0, 0);
      push(b + 4, C_RD, 5, 7, 1, 2);
      send(1'b1, 5, 9, 2, 3, a2);
      check("hit_ready_back", a2 - b, 5);
      push(b + 6, C_WR, 5, 9, 2, 3);
      push(b + 12, C_PRE, 0, 0, 0, 0);
      idle(20);
      check("hit_sb_empty", sbq.size(), 0);

      // Miss: PRE at ras expiry, new ACT after rp, which also meets rc from the first ACT.
      do_reset();
      send(1'b0, 5, 7, 1, 2, b);
      push(b + 1, C_ACT, 5, 0, 0, 0);
      push(b + 4, C_RD, 5, 7, 1, 2);
      send(1'b0, 9, 11, 6, 5, a2);
      check("miss_accept", a2 - b, 5);
      push(b + 9,  C_PRE, 0, 0, 0, 0);
      push(b + 12, C_ACT, 9, 0, 0, 0);
      push(b + 15, C_RD, 9, 11, 6, 5);
      push(b + 20, C_PRE, 0, 0, 0, 0);
      idle(30);
      check("miss_sb_empty", sbq.size(), 0);

      // Reset between ACT and RD: grants drop immediately and the pending read is lost.
      do_reset();
      send(1'b0, 5, 7, 1, 2, b);
      push(b + 1, C_ACT, 5, 0, 0, 0);
      @(negedge clk); @(negedge clk); #2;
      rst_n = 1'b0; #1;
      check("midrst_gnts", gnts, 0);
      check("midrst_ready", rif.ready, 0);
      check("midrst_sb_empty", sbq.size(), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      check("midrst_ready_low", rif.ready, 0);
      @(negedge clk);
      check("midrst_ready_high", rif.ready, 1);
      idle(15);
      check("midrst_no_rd", sbq.size(), 0);

`ifdef SAL_BK_REF_EN
      // Refresh with a pending hit: PRE, REF after rp, then ACT+RD of the held request after rfc.
      do_reset();
      send(1'b0, 5, 7, 1, 2, b);
      push(b + 1, C_ACT, 5, 0, 0, 0);
      @(negedge clk); #1;
      ref_req = 1'b1;
      push(b + 9,  C_PRE, 0, 0, 0, 0);
      push(b + 12, C_REF, 0, 0, 0, 0);
      push(b + 23, C_ACT, 5, 0, 0, 0);
      push(b + 26, C_RD, 5, 7, 1, 2);
      push(b + 31, C_PRE, 0, 0, 0, 0);
      while (cyc < b + 12) @(negedge clk);
      #1 ref_req = 1'b0;
      idle(30);
      check("ref_sb_empty", sbq.size(), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
